// File: rtl/pipeline_control.sv
// Pipeline hazard and stall controller: load-use interlock, branch flush,
// memory-wait freeze with timeout trap, HALT drain, and a saturating stall
// counter. Enables and flushes are combinational; everything else is state.
module pipeline_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EX_memread,
  input  logic [2:0]       EX_rt,
  input  logic [2:0]       ID_rs,
  input  logic [2:0]       ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             EX_branch_taken,
  input  logic             halt_req,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PCwrite,
  output logic             IF_IDwrite,
  output logic             ID_EXwrite,
  output logic             EX_MEMwrite,
  output logic             IF_IDflush,
  output logic             ID_EXflush,
  output logic             MEM_WBbubble,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout,
  output logic             halted
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    DRAIN    = 3'd2,
    HALTED   = 3'd3,
    ERROR    = 3'd4
  } state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [1:0]       drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic             halted_q, halted_d;

  logic mem_stall;
  logic load_use;
  logic run_eval;

  assign mem_stall = mem_req && !mem_ready;
  assign load_use  = EX_memread && ((ID_use_rs && (EX_rt == ID_rs)) ||
                                    (ID_use_rt && (EX_rt == ID_rt)));

  // MEM_WAIT with data ready behaves exactly like RUN without a memory stall.
  assign run_eval = ((state_q == RUN) && !mem_stall) ||
                    ((state_q == MEM_WAIT) && mem_ready);

  // State and counter registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      drain_cnt_q    <= '0;
      stall_cycles_q <= '0;
      mem_timeout_q  <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      mem_timeout_q  <= mem_timeout_d;
      halted_q       <= halted_d;
    end
  end

  // Next-state and counter update logic.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          if (wait_cnt_q == TIMEOUT_CNT) begin
            state_d       = ERROR;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      DRAIN: begin
        if (!mem_stall) begin
          if (drain_cnt_q == 2'd2) state_d = HALTED;
          else                     drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      HALTED, ERROR: ;
      default: state_d = ERROR;
    endcase
    // Branch outranks load-use and halt; only halt changes state here.
    if (run_eval) begin
      state_d = RUN;
      if (!EX_branch_taken && !load_use && halt_req) begin
        state_d     = DRAIN;
        drain_cnt_d = 2'd0;
      end
    end
    halted_d = (state_d == HALTED);

    stall_cycles_d = stall_cycles_q;
    if (!PCwrite && ((state_q == RUN) || (state_q == MEM_WAIT) || (state_q == DRAIN)) &&
        !(&stall_cycles_q))
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  // Pipeline register enables, flushes and bubble for the current cycle.
  always_comb begin
    PCwrite      = 1'b1;
    IF_IDwrite   = 1'b1;
    ID_EXwrite   = 1'b1;
    EX_MEMwrite  = 1'b1;
    IF_IDflush   = 1'b0;
    ID_EXflush   = 1'b0;
    MEM_WBbubble = 1'b0;
    if (reset) begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (!run_eval) begin
            PCwrite      = 1'b0;
            IF_IDwrite   = 1'b0;
            ID_EXwrite   = 1'b0;
            EX_MEMwrite  = 1'b0;
            MEM_WBbubble = 1'b1;
          end else if (EX_branch_taken) begin
            IF_IDflush = 1'b1;
            ID_EXflush = 1'b1;
          end else if (load_use) begin
            PCwrite    = 1'b0;
            IF_IDwrite = 1'b0;
            ID_EXflush = 1'b1;
          end else if (halt_req) begin
            PCwrite    = 1'b0;
            IF_IDflush = 1'b1;
          end
        end
        DRAIN: begin
          PCwrite    = 1'b0;
          IF_IDwrite = 1'b0;
          ID_EXflush = 1'b1;
          if (mem_stall) begin
            ID_EXwrite   = 1'b0;
            EX_MEMwrite  = 1'b0;
            MEM_WBbubble = 1'b1;
          end
        end
        default: begin
          PCwrite      = 1'b0;
          IF_IDwrite   = 1'b0;
          ID_EXwrite   = 1'b0;
          EX_MEMwrite  = 1'b0;
          MEM_WBbubble = 1'b1;
        end
      endcase
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_cycles_q;
  assign mem_timeout  = mem_timeout_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control. Control outputs are packed as
// {PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, IF_IDflush, ID_EXflush, MEM_WBbubble}.
module tb_pipeline_control;

  localparam int CNT_W = 4;

  localparam logic [6:0] C_DEF   = 7'b1111_000;
  localparam logic [6:0] C_FRZ   = 7'b0000_001;
  localparam logic [6:0] C_BR    = 7'b1111_110;
  localparam logic [6:0] C_LU    = 7'b0011_010;
  localparam logic [6:0] C_HALT  = 7'b0111_100;
  localparam logic [6:0] C_DRAIN = 7'b0011_010;
  localparam logic [6:0] C_DRMEM = 7'b0000_011;

  logic clk = 1'b0;
  logic reset;
  logic EX_memread, ID_use_rs, ID_use_rt, EX_branch_taken, halt_req, mem_req, mem_ready;
  logic [2:0] EX_rt, ID_rs, ID_rt;
  logic PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, IF_IDflush, ID_EXflush, MEM_WBbubble;
  logic [2:0] state;
  logic [CNT_W-1:0] stall_cycles;
  logic mem_timeout, halted;
  logic [6:0] ctrl;

  int checks = 0;
  int errors = 0;

  pipeline_control #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .EX_memread(EX_memread), .EX_rt(EX_rt), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
    .EX_branch_taken(EX_branch_taken), .halt_req(halt_req),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .PCwrite(PCwrite), .IF_IDwrite(IF_IDwrite), .ID_EXwrite(ID_EXwrite),
    .EX_MEMwrite(EX_MEMwrite), .IF_IDflush(IF_IDflush), .ID_EXflush(ID_EXflush),
    .MEM_WBbubble(MEM_WBbubble), .state(state), .stall_cycles(stall_cycles),
    .mem_timeout(mem_timeout), .halted(halted)
  );

  always #5 clk = ~clk;

  assign ctrl = {PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, IF_IDflush, ID_EXflush, MEM_WBbubble};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    EX_memread = 0; EX_rt = 0; ID_rs = 0; ID_rt = 0; ID_use_rs = 0; ID_use_rt = 0;
    EX_branch_taken = 0; halt_req = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic load_use_in();
    EX_memread = 1; EX_rt = 3'd3; ID_rs = 3'd3; ID_use_rs = 1;
  endtask

  // Inputs change 1 time unit after a rising edge; checks sample 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    tick();
    reset = 1;
  endtask

  initial begin
    // Reset holds defaults even with hostile inputs.
    idle();
    reset = 0;
    mem_req = 1; EX_branch_taken = 1; halt_req = 1;
    #3;
    check("rst_ctrl", 32'(ctrl), 32'(C_DEF));
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_stall", 32'(stall_cycles), 32'd0);
    check("rst_flags", {30'd0, mem_timeout, halted}, 32'd0);
    idle();
    reset = 1;

    // Load-use stall, then same hazard without rs use.
    load_use_in();
    #1 check("lu_ctrl", 32'(ctrl), 32'(C_LU));
    check("lu_stall0", 32'(stall_cycles), 32'd0);
    tick();
    ID_use_rs = 0;
    #1 check("lu_stall1", 32'(stall_cycles), 32'd1);
    check("nouse_ctrl", 32'(ctrl), 32'(C_DEF));
    tick();
    // Branch beats load-use.
    load_use_in(); EX_branch_taken = 1;
    #1 check("br_lu_ctrl", 32'(ctrl), 32'(C_BR));
    tick();
    idle();
    #1 check("br_lu_stall", 32'(stall_cycles), 32'd1);

    // Memory wait: four frozen cycles then release.
    do_reset();
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      #1 check("mw_ctrl", 32'(ctrl), 32'(C_FRZ));
      check("mw_state", 32'(state), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    mem_ready = 1;
    #1 check("mw_rel_ctrl", 32'(ctrl), 32'(C_DEF));
    tick();
    idle();
    #1 check("mw_rel_state", 32'(state), 32'd0);
    check("mw_rel_stall", 32'(stall_cycles), 32'd4);

    // Ready in MEM_WAIT with a branch acts as RUN; then halt from MEM_WAIT.
    do_reset();
    mem_req = 1;
    tick();
    mem_ready = 1; EX_branch_taken = 1;
    #1 check("mw_br_ctrl", 32'(ctrl), 32'(C_BR));
    tick();
    #1 check("mw_br_state", 32'(state), 32'd0);
    mem_ready = 0; EX_branch_taken = 0;
    tick();
    mem_ready = 1; halt_req = 1;
    #1 check("mw_halt_ctrl", 32'(ctrl), 32'(C_HALT));
    tick();
    idle();
    #1 check("mw_halt_state", 32'(state), 32'd2);

    // Timeout: sixteen frozen cycles, then ERROR until reset.
    do_reset();
    mem_req = 1;
    for (int i = 0; i < 16; i++) begin
      #1 check("to_ctrl", 32'(ctrl), 32'(C_FRZ));
      tick();
    end
    #1 check("to_state", 32'(state), 32'd4);
    check("to_flag", 32'(mem_timeout), 32'd1);
    check("to_ctrl_err", 32'(ctrl), 32'(C_FRZ));
    check("to_stall_sat", 32'(stall_cycles), 32'd15);
    mem_ready = 1;
    tick();
    check("to_sticky", 32'(state), 32'd4);
    reset = 0;
    #1 check("to_rst_state", 32'(state), 32'd0);
    check("to_rst_flag", 32'(mem_timeout), 32'd0);
    check("to_rst_ctrl", 32'(ctrl), 32'(C_DEF));
    idle();
    reset = 1;

    // Halt: one RUN stall, three DRAIN cycles, then HALTED.
    do_reset();
    halt_req = 1;
    #1 check("halt_ctrl", 32'(ctrl), 32'(C_HALT));
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1 check("drain_state", 32'(state), 32'd2);
      check("drain_ctrl", 32'(ctrl), 32'(C_DRAIN));
      tick();
    end
    #1 check("halted_state", 32'(state), 32'd3);
    check("halted_flag", 32'(halted), 32'd1);
    check("halted_ctrl", 32'(ctrl), 32'(C_FRZ));
    check("halted_stall", 32'(stall_cycles), 32'd4);
    tick();
    check("halted_stays", 32'(state), 32'd3);

    // Halt with one memory stall inside DRAIN: four DRAIN cycles.
    do_reset();
    halt_req = 1;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      mem_req = (i == 1);
      #1 check("drm_state", 32'(state), 32'd2);
      check("drm_ctrl", 32'(ctrl), (i == 1) ? 32'(C_DRMEM) : 32'(C_DRAIN));
      tick();
    end
    idle();
    #1 check("drm_halted", 32'(state), 32'd3);
    check("drm_stall", 32'(stall_cycles), 32'd5);

    // Counter saturation over 2^CNT_W+5 load-use cycles.
    do_reset();
    load_use_in();
    for (int i = 0; i < (1 << CNT_W) + 5; i++) tick();
    #1 check("sat_stall", 32'(stall_cycles), 32'(4'hF));
    check("sat_state", 32'(state), 32'd0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
